// File: rtl/stage_fetch.sv
// stage_fetch: instruction fetch stage with a 2-entry in-order queue.
//
// Issues one instruction-memory read at a time and queues returned words
// (with their addresses) for decode. Decode can stall, and can redirect the
// fetch stream. A redirect that arrives while a read is still in flight
// parks the target in KILL until that read's ack arrives, then drops the
// returned data.
//
// Handshakes:
//   imem: imem_req/imem_addr are held stable from the cycle imem_req rises
//         until the cycle imem_ack=1. imem_rdata is consumed only in the
//         imem_ack cycle. The ack may come in the same cycle as the request.
//   decode: an instruction transfers on a rising edge where de_valid=1 and
//         de_stall=0. While de_stall=1, de_valid/de_insn/de_pc do not change.
//
// Ports:
//   clk, reset_n          clock; synchronous active-low reset
//   de_stall              decode cannot take the head instruction
//   de_setpc, de_newpc    redirect request and target (low 2 bits ignored)
//   imem_req, imem_addr   read request and word-aligned address
//   imem_ack, imem_rdata  read completion and instruction word
//   de_valid, de_insn,    registered head of the queue
//   de_pc
//   fsm_state             debug view of the FSM: 0 = RUN, 1 = KILL
module stage_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        de_stall,
    input  logic        de_setpc,
    input  logic [31:0] de_newpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        de_valid,
    output logic [31:0] de_insn,
    output logic [31:0] de_pc,
    output logic        fsm_state
);

    typedef enum logic {
        RUN  = 1'b0,
        KILL = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] redirect_pc;

    // Second (younger) queue slot; the head slot is de_valid/de_insn/de_pc.
    logic        q1_valid;
    logic [31:0] q1_insn;
    logic [31:0] q1_pc;

    logic [31:0] target;
    logic        push;
    logic        pop;
    logic        newpc_unused;

    assign target       = {de_newpc[31:2], 2'b00};
    assign newpc_unused = ^de_newpc[1:0];

    // In KILL the old request must stay up until its ack. In RUN a request
    // is made whenever there is room. Only a push can fill the queue, and a
    // push needs an ack, so an open request never drops before its ack.
    assign imem_req  = reset_n & ((state == KILL) | ~(de_valid & q1_valid));
    assign imem_addr = fetch_pc;
    assign fsm_state = (state == KILL);

    assign push = imem_req & imem_ack & (state == RUN) & ~de_setpc;
    assign pop  = de_valid & ~de_stall;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            redirect_pc <= RESET_PC;
            de_valid    <= 1'b0;
            de_insn     <= 32'h0;
            de_pc       <= 32'h0;
            q1_valid    <= 1'b0;
            q1_insn     <= 32'h0;
            q1_pc       <= 32'h0;
        end else begin
            // Fetch address and FSM.
            case (state)
                RUN: begin
                    if (de_setpc) begin
                        if (imem_req && !imem_ack) begin
                            // The read in flight cannot be withdrawn, so
                            // wait for its ack before using the target.
                            state       <= KILL;
                            redirect_pc <= target;
                        end else begin
                            fetch_pc <= target;
                        end
                    end else if (imem_req && imem_ack) begin
                        fetch_pc <= fetch_pc + 32'd4;
                    end
                end
                KILL: begin
                    if (imem_ack) begin
                        state    <= RUN;
                        fetch_pc <= de_setpc ? target : redirect_pc;
                    end else if (de_setpc) begin
                        redirect_pc <= target;
                    end
                end
                default: state <= RUN;
            endcase

            // Queue. A redirect drops everything younger than a stalled
            // head; an unstalled head is consumed this cycle anyway.
            if (de_setpc) begin
                q1_valid <= 1'b0;
                if (!(de_valid && de_stall)) begin
                    de_valid <= 1'b0;
                end
            end else if (pop) begin
                if (q1_valid) begin
                    de_insn  <= q1_insn;
                    de_pc    <= q1_pc;
                    q1_valid <= push;
                    if (push) begin
                        q1_insn <= imem_rdata;
                        q1_pc   <= imem_addr;
                    end
                end else if (push) begin
                    de_insn <= imem_rdata;
                    de_pc   <= imem_addr;
                end else begin
                    de_valid <= 1'b0;
                end
            end else if (push) begin
                if (de_valid) begin
                    q1_valid <= 1'b1;
                    q1_insn  <= imem_rdata;
                    q1_pc    <= imem_addr;
                end else begin
                    de_valid <= 1'b1;
                    de_insn  <= imem_rdata;
                    de_pc    <= imem_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_stage_fetch.sv
// Testbench for stage_fetch.
// A memory responder with configurable latency answers each request with a
// word derived from its address. A monitor keeps the expected address of
// the next instruction decode should accept (sequential +4, replaced by
// redirect targets) and checks every accepted instruction against it, along
// with stall stability and request stability. Scenario tasks add directed
// cycle-exact checks.
module tb_stage_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        de_stall;
    logic        de_setpc;
    logic [31:0] de_newpc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        de_valid;
    logic [31:0] de_insn;
    logic [31:0] de_pc;
    logic        fsm_state;

    int n_pass  = 0;
    int n_total = 0;

    int mem_lat  = 0;
    bit lat_rand = 0;
    int mem_cnt  = 0;
    int pop_count = 0;

    logic [31:0] exp_pc   = RST_PC;
    logic [31:0] after_pc = 32'h0;
    bit          has_after = 0;

    bit          prev_ok = 0;
    bit          prev_hold = 0;
    bit          prev_wait = 0;
    logic [31:0] prev_insn, prev_pc, prev_addr;

    stage_fetch #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .de_stall   (de_stall),
        .de_setpc   (de_setpc),
        .de_newpc   (de_newpc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .de_valid   (de_valid),
        .de_insn    (de_insn),
        .de_pc      (de_pc),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] insn_of(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16]};
    endfunction

    // Memory responder: acks after mem_lat waiting cycles.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (!reset_n) begin
                imem_ack = 1'b0;
                mem_cnt  = 0;
            end else if (imem_req) begin
                if (mem_cnt >= mem_lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = insn_of(imem_addr);
                    mem_cnt    = 0;
                    if (lat_rand) mem_lat = $urandom_range(0, 3);
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = $urandom;
                    mem_cnt++;
                end
            end else begin
                imem_ack = 1'b0;
                mem_cnt  = 0;
            end
        end
    end

    // Reference model and per-cycle protocol monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                exp_pc    = RST_PC;
                has_after = 0;
                prev_ok   = 0;
            end else begin
                if (prev_ok && prev_hold) begin
                    n_total++;
                    if ({de_valid, de_insn, de_pc} !== {1'b1, prev_insn, prev_pc})
                        $display("FAIL stall_hold: got v=%b insn=%h pc=%h expected v=1 insn=%h pc=%h",
                                 de_valid, de_insn, de_pc, prev_insn, prev_pc);
                    else n_pass++;
                end
                if (prev_ok && prev_wait) begin
                    n_total++;
                    if ({imem_req, imem_addr} !== {1'b1, prev_addr})
                        $display("FAIL req_hold: got req=%b addr=%h expected req=1 addr=%h",
                                 imem_req, imem_addr, prev_addr);
                    else n_pass++;
                end
                if (de_valid && !de_stall) begin
                    n_total++;
                    if (de_pc !== exp_pc)
                        $display("FAIL pop_pc: got %h expected %h", de_pc, exp_pc);
                    else n_pass++;
                    n_total++;
                    if (de_insn !== insn_of(exp_pc))
                        $display("FAIL pop_insn: got %h expected %h", de_insn, insn_of(exp_pc));
                    else n_pass++;
                    pop_count++;
                    if (has_after) begin
                        exp_pc    = after_pc;
                        has_after = 0;
                    end else begin
                        exp_pc = exp_pc + 32'd4;
                    end
                end
                if (de_setpc) begin
                    if (de_valid && de_stall) begin
                        after_pc  = {de_newpc[31:2], 2'b00};
                        has_after = 1;
                    end else begin
                        exp_pc    = {de_newpc[31:2], 2'b00};
                        has_after = 0;
                    end
                end
                prev_ok   = 1;
                prev_hold = de_valid && de_stall;
                prev_insn = de_insn;
                prev_pc   = de_pc;
                prev_wait = imem_req && !imem_ack;
                prev_addr = imem_addr;
            end
        end
    end

    // Leaves the caller 1 time unit into the first cycle with reset_n=1.
    task automatic apply_reset;
        @(posedge clk); #1;
        reset_n  = 1'b0;
        de_setpc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        mem_lat  = 0;
        de_stall = 1'b0;
        apply_reset();
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({de_valid, imem_req, fsm_state} !== 3'b000)
            $display("FAIL reset_ctrl: got valid=%b req=%b state=%b expected 0 0 0", de_valid, imem_req, fsm_state);
        else n_pass++;
        n_total++;
        if ({de_insn, de_pc} !== 64'h0)
            $display("FAIL reset_data: got insn=%h pc=%h expected 0 0", de_insn, de_pc);
        else n_pass++;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        n_total++;
        if ({imem_req, imem_addr} !== {1'b1, RST_PC})
            $display("FAIL reset_first_req: got req=%b addr=%h expected 1 %h", imem_req, imem_addr, RST_PC);
        else n_pass++;
    endtask

    task automatic test_zero_wait;
        mem_lat  = 0;
        de_stall = 1'b0;
        apply_reset();
        @(negedge clk);
        n_total++;
        if ({imem_req, imem_ack, de_valid, imem_addr} !== {3'b110, RST_PC})
            $display("FAIL zw_first: got req=%b ack=%b valid=%b addr=%h expected 1 1 0 %h",
                     imem_req, imem_ack, de_valid, imem_addr, RST_PC);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if ({de_valid, de_pc} !== {1'b1, RST_PC + 32'(4 * i)})
                $display("FAIL zw_stream%0d: got v=%b pc=%h expected 1 %h", i, de_valid, de_pc, RST_PC + 32'(4 * i));
            else n_pass++;
        end
    endtask

    task automatic test_stall_fill;
        int acks;
        acks     = 0;
        mem_lat  = 3;
        de_stall = 1'b1;
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (imem_ack) acks++;
            if (de_valid) begin
                n_total++;
                if (de_pc !== RST_PC)
                    $display("FAIL stall_pc%0d: got %h expected %h", i, de_pc, RST_PC);
                else n_pass++;
            end
            if (i == 11) begin
                n_total++;
                if ({imem_req, de_valid} !== 2'b01)
                    $display("FAIL stall_full: got req=%b valid=%b expected 0 1", imem_req, de_valid);
                else n_pass++;
            end
        end
        n_total++;
        if (acks !== 2)
            $display("FAIL stall_fetch_count: got %0d expected 2", acks);
        else n_pass++;
        @(posedge clk); #1;
        de_stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if ({de_valid, de_pc} !== {1'b1, RST_PC + 32'd4})
            $display("FAIL stall_release: got v=%b pc=%h expected 1 %h", de_valid, de_pc, RST_PC + 32'd4);
        else n_pass++;
    endtask

    task automatic test_redirect_kill;
        bit found;
        found    = 0;
        mem_lat  = 2;
        de_stall = 1'b0;
        apply_reset();
        de_setpc = 1'b1;
        de_newpc = 32'h0000_2002;
        @(posedge clk); #1;
        de_setpc = 1'b0;
        @(negedge clk);
        n_total++;
        if ({fsm_state, imem_req, imem_addr} !== {2'b11, RST_PC})
            $display("FAIL kill_enter: got state=%b req=%b addr=%h expected 1 1 %h", fsm_state, imem_req, imem_addr, RST_PC);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({imem_ack, imem_addr} !== {1'b1, RST_PC})
            $display("FAIL kill_ack: got ack=%b addr=%h expected 1 %h", imem_ack, imem_addr, RST_PC);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({fsm_state, imem_req, de_valid, imem_addr} !== {3'b010, 32'h0000_2000})
            $display("FAIL kill_exit: got state=%b req=%b valid=%b addr=%h expected 0 1 0 00002000",
                     fsm_state, imem_req, de_valid, imem_addr);
        else n_pass++;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (de_valid) found = 1;
        end
        n_total++;
        if (!found)
            $display("FAIL kill_timeout: got no de_valid expected de_valid within 20 cycles");
        else n_pass++;
        n_total++;
        if (de_pc !== 32'h0000_2000)
            $display("FAIL kill_target_pc: got %h expected 00002000", de_pc);
        else n_pass++;
    endtask

    task automatic test_kill_last_wins;
        mem_lat  = 3;
        de_stall = 1'b0;
        apply_reset();
        de_setpc = 1'b1;
        de_newpc = 32'h0000_2002;
        @(posedge clk); #1;
        de_newpc = 32'h0000_3001;
        @(posedge clk); #1;
        de_setpc = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if ({fsm_state, imem_ack, imem_addr} !== {2'b11, RST_PC})
            $display("FAIL last_wins_ack: got state=%b ack=%b addr=%h expected 1 1 %h", fsm_state, imem_ack, imem_addr, RST_PC);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({fsm_state, imem_addr} !== {1'b0, 32'h0000_3000})
            $display("FAIL last_wins_addr: got state=%b addr=%h expected 0 00003000", fsm_state, imem_addr);
        else n_pass++;
    endtask

    task automatic test_head_keep;
        mem_lat  = 0;
        de_stall = 1'b1;
        apply_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        de_setpc = 1'b1;
        de_newpc = 32'h0000_0400;
        @(negedge clk);
        n_total++;
        if ({de_valid, imem_req} !== 2'b10)
            $display("FAIL keep_pre: got valid=%b req=%b expected 1 0", de_valid, imem_req);
        else n_pass++;
        @(posedge clk); #1;
        de_setpc = 1'b0;
        @(negedge clk);
        n_total++;
        if ({de_valid, de_pc, imem_req, imem_addr} !== {1'b1, RST_PC, 1'b1, 32'h0000_0400})
            $display("FAIL keep_head: got v=%b pc=%h req=%b addr=%h expected 1 %h 1 00000400",
                     de_valid, de_pc, imem_req, imem_addr, RST_PC);
        else n_pass++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        de_stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if ({de_valid, de_pc} !== {1'b1, 32'h0000_0400})
            $display("FAIL keep_next: got v=%b pc=%h expected 1 00000400", de_valid, de_pc);
        else n_pass++;
    endtask

    task automatic test_wrap;
        mem_lat  = 0;
        de_stall = 1'b0;
        apply_reset();
        de_setpc = 1'b1;
        de_newpc = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        de_setpc = 1'b0;
        @(negedge clk);
        n_total++;
        if (imem_addr !== 32'hFFFF_FFFC)
            $display("FAIL wrap_top: got %h expected fffffffc", imem_addr);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({imem_addr, de_valid, de_pc} !== {32'h0, 1'b1, 32'hFFFF_FFFC})
            $display("FAIL wrap_zero: got addr=%h v=%b pc=%h expected 00000000 1 fffffffc", imem_addr, de_valid, de_pc);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (de_pc !== 32'h0)
            $display("FAIL wrap_pc: got %h expected 00000000", de_pc);
        else n_pass++;
    endtask

    task automatic test_reset_in_kill;
        mem_lat  = 5;
        de_stall = 1'b0;
        apply_reset();
        de_setpc = 1'b1;
        de_newpc = 32'h0000_0800;
        @(posedge clk); #1;
        de_setpc = 1'b0;
        @(negedge clk);
        n_total++;
        if ({fsm_state, imem_req} !== 2'b11)
            $display("FAIL rk_in_kill: got state=%b req=%b expected 1 1", fsm_state, imem_req);
        else n_pass++;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if ({de_valid, fsm_state, imem_req} !== 3'b000)
            $display("FAIL rk_reset: got valid=%b state=%b req=%b expected 0 0 0", de_valid, fsm_state, imem_req);
        else n_pass++;
        reset_n = 1'b1;
        @(negedge clk);
        n_total++;
        if ({imem_req, imem_addr} !== {1'b1, RST_PC})
            $display("FAIL rk_restart: got req=%b addr=%h expected 1 %h", imem_req, imem_addr, RST_PC);
        else n_pass++;
    endtask

    task automatic test_random;
        mem_lat  = 0;
        lat_rand = 1;
        de_stall = 1'b0;
        apply_reset();
        pop_count = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            de_stall = ($urandom_range(0, 3) == 0);
            de_setpc = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0)
                de_newpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else
                de_newpc = $urandom;
        end
        @(posedge clk); #1;
        de_setpc = 1'b0;
        de_stall = 1'b0;
        lat_rand = 0;
        n_total++;
        if (pop_count < 300)
            $display("FAIL rand_progress: got %0d accepted expected at least 300", pop_count);
        else n_pass++;
    endtask

    initial begin
        reset_n  = 1'b0;
        de_stall = 1'b0;
        de_setpc = 1'b0;
        de_newpc = 32'h0;
        test_reset();
        test_zero_wait();
        test_stall_fill();
        test_redirect_kill();
        test_kill_last_wins();
        test_head_keep();
        test_wrap();
        test_reset_in_kill();
        test_random();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
